// File: rtl/posit_stream_decode_if.sv
// Handshake and result bus of posit_stream_decode.
//   in_valid / in_ready / in_posit : encoded posit stream into the decoder
//   out_valid / out_ready          : decoded result handshake
//   out_sign, out_regime, out_exponent, out_fraction, out_scale,
//   out_zero, out_nar              : decoded result fields
// slave  : the decoder's view (consumes in_*, produces out_*)
// master : the producer/consumer view around the decoder
interface posit_stream_decode_if #(
    parameter int N  = 32,
    parameter int ES = 2
);
    localparam int RW = $clog2(N) + 1;
    localparam int FW = N - 3 - ES;
    localparam int SW = RW + ES;
    // ES=0 has no exponent field; keep a one-bit port tied to zero
    localparam int EW = (ES > 0) ? ES : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_posit;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic signed [RW-1:0] out_regime;
    logic [EW-1:0]        out_exponent;
    logic [FW-1:0]        out_fraction;
    logic signed [SW-1:0] out_scale;
    logic                 out_zero;
    logic                 out_nar;

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_regime, out_exponent,
               out_fraction, out_scale, out_zero, out_nar
    );

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_regime, out_exponent,
               out_fraction, out_scale, out_zero, out_nar
    );
endinterface

// File: rtl/posit_stream_decode.sv
// Two-stage pipelined posit decoder with valid/ready flow control.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : posit_stream_decode_if.slave (input stream + decoded result)
// Optional (macro POSIT_DEC_STATS_EN):
//   stat_total, stat_zero, stat_nar : 32-bit saturating counts of output
//   transfers (all items, zero items, NaR items)
// S1 registers sign, two's-complement magnitude and the zero/NaR flags.
// S2 decodes the regime run, exponent and fraction from the magnitude.
module posit_stream_decode #(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    posit_stream_decode_if.slave   bus
`ifdef POSIT_DEC_STATS_EN
    ,
    output logic [31:0]            stat_total,
    output logic [31:0]            stat_zero,
    output logic [31:0]            stat_nar
`endif
);
    localparam int RW = $clog2(N) + 1;
    localparam int FW = N - 3 - ES;
    localparam int SW = RW + ES;
    localparam int EW = (ES > 0) ? ES : 1;

    logic           s1_valid;
    logic           sign_p1;
    logic [N-2:0]   mag_p1;     // magnitude MSB only matters for NaR, which is flagged separately
    logic           zero_p1;
    logic           nar_p1;

    logic s2_en;
    logic s1_en;

    assign s2_en        = !bus.out_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    // ---- S1: sign, magnitude, special-case detection ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            sign_p1  <= 1'b0;
            mag_p1   <= '0;
            zero_p1  <= 1'b0;
            nar_p1   <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                sign_p1 <= bus.in_posit[N-1];
                mag_p1  <= bus.in_posit[N-1] ? N'(-bus.in_posit) : bus.in_posit;
                zero_p1 <= (bus.in_posit == '0);
                nar_p1  <= (bus.in_posit == {1'b1, {(N-1){1'b0}}});
            end
        end
    end

    // Regime run length, then shift the run and its terminator out so the
    // exponent and fraction sit at the MSB end of rem.
    int                   run;
    logic                 r0;
    logic                 run_end;
    logic [N-2:0]         rem;
    logic signed [RW-1:0] k_c;
    logic signed [SW-1:0] k_ext;
    logic [EW-1:0]        exp_c;
    logic [FW-1:0]        frac_c;
    logic signed [SW-1:0] scale_c;

    always_comb begin
        run     = 0;
        run_end = 1'b0;
        r0      = mag_p1[N-2];
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_end && (mag_p1[i] == r0)) run = run + 1;
            else                               run_end = 1'b1;
        end
        k_c     = r0 ? RW'(run - 1) : RW'(-run);
        rem     = mag_p1 << (run + 1);
        // ES=0 shifts everything out, leaving the exponent at zero
        exp_c   = EW'(rem >> (N - 1 - ES));
        // The two LSBs of rem can never carry payload (run+terminator >= 2)
        frac_c  = FW'(rem >> 2);
        k_ext   = SW'(k_c);
        scale_c = (k_ext <<< ES) + $signed(SW'(exp_c));
    end

    // ---- S2: decoded fields to the output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_sign     <= 1'b0;
            bus.out_regime   <= '0;
            bus.out_exponent <= '0;
            bus.out_fraction <= '0;
            bus.out_scale    <= '0;
            bus.out_zero     <= 1'b0;
            bus.out_nar      <= 1'b0;
        end else if (s2_en) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_sign <= sign_p1;
                bus.out_zero <= zero_p1;
                bus.out_nar  <= nar_p1;
                if (zero_p1 || nar_p1) begin
                    bus.out_regime   <= '0;
                    bus.out_exponent <= '0;
                    bus.out_fraction <= '0;
                    bus.out_scale    <= '0;
                end else begin
                    bus.out_regime   <= k_c;
                    bus.out_exponent <= exp_c;
                    bus.out_fraction <= frac_c;
                    bus.out_scale    <= scale_c;
                end
            end
        end
    end

`ifdef POSIT_DEC_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic out_fire;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= '0;
            stat_zero  <= '0;
            stat_nar   <= '0;
        end else if (out_fire) begin
            stat_total <= sat_inc(stat_total);
            if (bus.out_zero) stat_zero <= sat_inc(stat_zero);
            if (bus.out_nar)  stat_nar  <= sat_inc(stat_nar);
        end
    end
`endif
endmodule

// File: tb/tb_posit_stream_decode.sv
module tb_posit_stream_decode;
    typedef logic [98:0] rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    posit_stream_decode_if #(.N(16), .ES(1)) b16 ();
    posit_stream_decode_if #(.N(64), .ES(2)) b64 ();

`ifdef POSIT_DEC_STATS_EN
    logic [31:0] st16_t, st16_z, st16_n, st64_t, st64_z, st64_n;
`endif

    posit_stream_decode #(.N(16), .ES(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
`ifdef POSIT_DEC_STATS_EN
        , .stat_total(st16_t), .stat_zero(st16_z), .stat_nar(st16_n)
`endif
    );

    posit_stream_decode #(.N(64), .ES(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(b64)
`ifdef POSIT_DEC_STATS_EN
        , .stat_total(st64_t), .stat_zero(st64_z), .stat_nar(st64_n)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic rec_t pack(bit s, bit z, bit na, int k, int e,
                                  longint unsigned f, int sc);
        return {s, z, na, 8'(k), 8'(e), 64'(f), 16'(sc)};
    endfunction

    function automatic int bitat(logic [63:0] v, int i);
        if (i < 0) return 0;
        return int'(v[i]);
    endfunction

    // Reference decoder: walks the bit string from the MSB end
    function automatic rec_t model(int n, int es, logic [63:0] p_in);
        logic [63:0]     mask, p, v;
        int              i, m, k, e, sc, fw, r0;
        bit              s;
        longint unsigned f;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        p    = p_in & mask;
        fw   = n - 3 - es;
        if (p == 64'd0) return pack(0, 1, 0, 0, 0, 0, 0);
        if (p == (64'd1 << (n - 1))) return pack(1, 0, 1, 0, 0, 0, 0);
        s  = p[n-1];
        v  = s ? ((~p + 64'd1) & mask) : p;
        i  = n - 2;
        r0 = bitat(v, i);
        m  = 0;
        while (i >= 0) begin
            if (bitat(v, i) != r0) break;
            m++;
            i--;
        end
        k = (r0 == 1) ? m - 1 : -m;
        i--;
        e = 0;
        for (int j = 0; j < es; j++) begin
            e = e * 2 + bitat(v, i);
            i--;
        end
        f = 0;
        for (int j = 0; j < fw; j++) begin
            f = f * 2 + longint'(bitat(v, i));
            i--;
        end
        sc = k * (1 << es) + e;
        return pack(s, 0, 0, k, e, f, sc);
    endfunction

    function automatic rec_t obs16();
        return pack(b16.out_sign, b16.out_zero, b16.out_nar, int'(b16.out_regime),
                    int'(b16.out_exponent), 64'(b16.out_fraction), int'(b16.out_scale));
    endfunction

    function automatic rec_t obs64();
        return pack(b64.out_sign, b64.out_zero, b64.out_nar, int'(b64.out_regime),
                    int'(b64.out_exponent), 64'(b64.out_fraction), int'(b64.out_scale));
    endfunction

    rec_t q16[$];
    int   c16[$];
    rec_t q64[$];
    bit   lat16 = 1'b0;
    bit   held16_v = 1'b0;
    rec_t held16;
    int   pop64 = 0, nz64 = 0, nn64 = 0;

    always @(negedge clk) begin
        rec_t r, e;
        int   c;
        if (!rst_n) begin
            held16_v = 1'b0;
        end else begin
            cyc++;
            r = obs16();
            if (held16_v) chk("hold16", {b16.out_valid, r}, {1'b1, held16});
            held16_v = b16.out_valid && !b16.out_ready;
            held16   = r;
            chk("in_ready16", b16.in_ready,
                !(b16.out_valid && !b16.out_ready && q16.size() == 2));
            if (b16.out_valid && b16.out_ready) begin
                if (q16.size() == 0) begin
                    chk("unexpected_out16", b16.out_valid, 1'b0);
                end else begin
                    e = q16.pop_front();
                    c = c16.pop_front();
                    chk("data16", r, e);
                    if (lat16) chk("latency16", cyc - c, 2);
                end
            end
        end
    end

    always @(negedge clk) begin
        rec_t e;
        if (rst_n) begin
            chk("in_ready64", b64.in_ready, !(b64.out_valid && !b64.out_ready && q64.size() == 2));
            if (b64.out_valid && b64.out_ready) begin
                if (q64.size() == 0) begin
                    chk("unexpected_out64", b64.out_valid, 1'b0);
                end else begin
                    e = q64.pop_front();
                    chk("data64", obs64(), e);
                    pop64++;
                    if (e[97]) nz64++;
                    if (e[96]) nn64++;
                end
            end
        end
    end

    task automatic send16(input logic [15:0] p, input rec_t e);
        int t = 0;
        b16.in_posit = p;
        b16.in_valid = 1'b1;
        @(negedge clk);
        while (!b16.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!b16.in_ready) begin
            chk("accept16", b16.in_ready, 1'b1);
        end else begin
            @(posedge clk);
            q16.push_back(e);
            c16.push_back(cyc);
        end
        #1;
    endtask

    task automatic send64(input logic [63:0] p);
        int t = 0;
        b64.in_posit = p;
        b64.in_valid = 1'b1;
        @(negedge clk);
        while (!b64.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!b64.in_ready) begin
            chk("accept64", b64.in_ready, 1'b1);
        end else begin
            @(posedge clk);
            q64.push_back(model(64, 2, p));
        end
        #1;
    endtask

    task automatic drain16();
        int t = 0;
        while (q16.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain16", q16.size(), 0);
        #1;
    endtask

    task automatic drain64();
        int t = 0;
        while (q64.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain64", q64.size(), 0);
        @(negedge clk);
        #1;
    endtask

    logic [15:0] strm [8] = '{16'h1234, 16'hFEDC, 16'h6A00, 16'h0000,
                              16'h8000, 16'h9F01, 16'h7FFF, 16'h0003};
    bit          pat  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit          sweep_done = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        int          sel;
        rst_n = 1'b0;
        b16.in_valid = 1'b0; b16.in_posit = '0; b16.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_posit = '0; b64.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_valid16", b16.out_valid, 1'b0);
        chk("rst_fields16", obs16(), '0);
        chk("rst_valid64", b64.out_valid, 1'b0);
        chk("rst_fields64", obs64(), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready16", b16.in_ready, 1'b1);

        // Directed values with hand-derived expectations, latency checked
        lat16 = 1'b1;
        send16(16'h4000, pack(0, 0, 0, 0, 0, 0, 0));
        send16(16'h4800, pack(0, 0, 0, 0, 0, 64'h800, 0));
        send16(16'h5000, pack(0, 0, 0, 0, 1, 0, 1));
        send16(16'hC000, pack(1, 0, 0, 0, 0, 0, 0));
        send16(16'h0000, pack(0, 1, 0, 0, 0, 0, 0));
        send16(16'h8000, pack(1, 0, 1, 0, 0, 0, 0));
        send16(16'h7FFF, pack(0, 0, 0, 14, 0, 0, 28));
        send16(16'h0001, pack(0, 0, 0, -14, 0, 0, -28));
        b16.in_valid = 1'b0;
        drain16();
        lat16 = 1'b0;

        // Back-to-back stream under backpressure
        fork
            begin
                for (int i = 0; i < 8; i++) send16(strm[i], model(16, 1, 64'(strm[i])));
                b16.in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    b16.out_ready = pat[i];
                    @(posedge clk);
                    #1;
                end
                b16.out_ready = 1'b1;
            end
        join
        drain16();

        // Reset with two items in flight
        b16.out_ready = 1'b0;
        send16(16'h4800, model(16, 1, 64'h4800));
        send16(16'h5000, model(16, 1, 64'h5000));
        b16.in_valid = 1'b0;
        #2;
        chk("pre_rst_valid16", b16.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid16", b16.out_valid, 1'b0);
        chk("rst_in_ready16", b16.in_ready, 1'b1);
        q16.delete();
        c16.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        b16.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_valid16", b16.out_valid, 1'b0);
        chk("post_rst_in_ready16", b16.in_ready, 1'b1);
`ifdef POSIT_DEC_STATS_EN
        chk("stat16_cleared", st16_t, 32'd0);
`endif

        // N=64, ES=2 random sweep with random backpressure
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    p   = {$urandom, $urandom};
                    sel = $urandom_range(0, 63);
                    if (sel == 0)      p = 64'd0;
                    else if (sel == 1) p = 64'h8000_0000_0000_0000;
                    else if (sel == 2) p = 64'h7FFF_FFFF_FFFF_FFFF;
                    else if (sel == 3) p = 64'd1;
                    else if (sel < 12) p = p >> $urandom_range(1, 62);
                    else if (sel < 16) p = ~(p >> $urandom_range(1, 62));
                    send64(p);
                    if ($urandom_range(0, 15) == 0) begin
                        b64.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                b64.in_valid = 1'b0;
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    b64.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                b64.out_ready = 1'b1;
            end
        join
        drain64();
        chk("count64", pop64, 10000);
`ifdef POSIT_DEC_STATS_EN
        chk("stat_total64", st64_t, 32'd10000);
        chk("stat_zero64", st64_z, 32'(nz64));
        chk("stat_nar64", st64_n, 32'(nn64));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/posit_stream_decode.md
Name: posit_stream_decode

Overview:
- Parametrised, pipelined posit decoder for any width N and exponent size ES.
- Sits between the operand buffers and the arithmetic datapath.
- Accepts one encoded posit per cycle over a valid/ready handshake. Emits sign, regime, exponent, fraction, combined scale and special-case flags two cycles later.
- Backpressure from the datapath stalls the pipeline without loss or duplication.

Parameters:
- N, 32, posit width in bits; legal 8..64.
- ES, 2, exponent field width; legal 0..N-4.
- Derived RW = $clog2(N)+1: signed regime width.
- Derived FW = N-3-ES: fraction width, left-aligned, hidden bit excluded.
- Derived SW = RW+ES: signed scale width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_posit is valid.
- in_ready  out  1  decoder can accept this cycle.
- in_posit  in  N  encoded posit.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts.
- out_sign  out  1  sign bit.
- out_regime  out  RW  signed regime k.
- out_exponent  out  ES  exponent field, zero-padded where truncated.
- out_fraction  out  FW  fraction bits, MSB-aligned, zero-padded.
- out_scale  out  SW  signed k*2^ES + exponent.
- out_zero  out  1  input was 0.
- out_nar  out  1  input was NaR (1 followed by N-1 zeros).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: out_valid=0 and internal s1_valid=0. All data registers and outputs are 0. in_ready=1 while rst_n is high and the pipeline is empty.
- Reset asserted mid-operation: in-flight items are discarded. No output appears after release.
- Pipeline: two register stages, S1 and S2. Latency is exactly 2 cycles from the input handshake to out_valid when out_ready is held 1. Throughput is 1 item per cycle.
- Handshake:
  - Transfer on a port occurs when valid and ready are both 1.
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en, combinational from out_ready.
  - out_valid and all out_* fields hold stable while out_valid=1 and out_ready=0.
- S1 (on in transfer):
  - Register sign = in_posit[N-1].
  - Register mag = sign ? -in_posit : in_posit (two's complement, N bits).
  - Register zero = (in_posit == 0) and nar = (in_posit == 1<<(N-1)).
- S2:
  - Leading-run detect on mag[N-2:0]. r0 = mag[N-2]; m = length of the run of r0.
  - k = r0 ? m-1 : -m.
  - Remaining bits after the run and its terminator are shifted left to MSB.
  - The top ES bits form the exponent; the next FW bits form the fraction. Missing bits are zero.
- Scale: out_scale = (k <<< ES) + exponent, sign-extended arithmetic.
- Boundaries:
  - maxpos: the run fills all N-1 bits, no terminator, k=N-2, exponent=0, fraction=0.
  - minpos: k=-(N-2).
  - zero and NaR: regime, exponent, fraction and scale are forced to 0, and the respective flag is set. out_sign=0 for zero and 1 for NaR.
- Simultaneous events: a new input is accepted in the same cycle S1 drains into S2 and S2 drains to the output. There are no bubbles.
- Empty output stage: when out_valid=0, in_ready=1 regardless of out_ready.

Optional Feature:
- Macro POSIT_DEC_STATS_EN.
- When defined, the block adds output ports stat_total (32), stat_zero (32) and stat_nar (32).
  - These are saturating counters, incremented on each output transfer for all items, zero items and NaR items respectively.
  - They are reset to 0 by rst_n.
  - They hold at 32'hFFFF_FFFF once saturated.
- When not defined, the ports and logic are absent, and the block behaviour is otherwise identical.

Test Plan (N=16, ES=1 unless stated):
- 0x4000, out_ready=1 -> 2 cycles later: sign 0, regime 0, exponent 0, fraction 0x000, scale 0.
- 0x4800 -> fraction 0x800, exponent 0, scale 0. Then 0x5000 -> exponent 1, scale 1. Then 0xC000 -> sign 1, regime 0, fraction 0.
- 0x0000 -> zero=1, all fields 0. 0x8000 -> nar=1, sign 1, fields 0. 0x7FFF -> regime 14, scale 28. 0x0001 -> regime -14, scale -28.
- Back-to-back stream of 8 values with out_ready toggled 1,0,0,1,0,1,1,1:
  - Outputs match in order, none dropped or duplicated.
  - in_ready=0 only when both stages are full and out_ready=0.
  - Fields are stable during stalls.
- Assert rst_n low while 2 items are in flight -> out_valid falls immediately (asynchronously). After release, no stale output appears and in_ready=1.
- N=64, ES=2 sweep of 10,000 random posits -> fields match the reference model. With POSIT_DEC_STATS_EN defined, stat_total=10000 and stat_zero and stat_nar match the model counts.
